csr_irq_scheduler: RTL
======================

Name: csr_irq_scheduler

Overview:
- Selects, prioritises and schedules pending interrupts against the mstatus interrupt enables and the current privilege mode.
- Owns the WFI sequencing state machine, including the mstatus.TW timeout.
- Sits in the privileged unit beside the status register. It produces a stable, registered interrupt request and cause for trap generation, and consumes the trap acknowledge.

Parameters:
- S_SUPPORTED, 1, supervisor mode implemented; 0 forces all S-targeted interrupts off and ignores MIDELEG.
- U_SUPPORTED, 1, user mode implemented; 0 with S_SUPPORTED=0 ignores STATUS_TW.
- WFI_TIMEOUT, 16, cycles spent in WFI at lower privilege with TW=1 before the illegal-instruction timeout; range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallW  in  1  pipeline writeback stall
- MIP_REGW  in  12  interrupt pending bits
- MIE_REGW  in  12  interrupt enable bits
- MIDELEG_REGW  in  12  interrupt delegation to S
- STATUS_MIE  in  1  mstatus.MIE
- STATUS_SIE  in  1  mstatus.SIE
- STATUS_TW  in  1  mstatus.TW
- PrivilegeModeW  in  2  current mode (11=M, 01=S, 00=U)
- wfiM  in  1  WFI instruction in Memory stage
- TrapM  in  1  trap taken (acknowledge)
- InterruptPendingM  out  1  registered interrupt request
- InterruptCauseM  out  4  cause code of the request
- InterruptToSM  out  1  request targets S (delegated)
- WfiStallM  out  1  hold pipeline while sleeping
- WfiTimeoutM  out  1  one-cycle pulse: WFI becomes illegal-instruction trap

Behaviour:
- Reset: state RUN, counter 0, all outputs 0. Reset in any state, including mid-WFI or MASK, returns to RUN next cycle.
- Only bits 1, 3, 5, 7, 9 and 11 are considered. Other bits are ignored. PE = MIP_REGW & MIE_REGW.
- M-target set: PE & ~DELEG, enabled when Priv!=M or STATUS_MIE.
- S-target set: PE & DELEG, enabled when Priv==U or (Priv==S & STATUS_SIE). The S-target set is never enabled in M mode.
- DELEG = MIDELEG_REGW if S_SUPPORTED, else 0.
- If the M-target set is non-empty, it wins. Within a set, priority is 11 > 3 > 7 > 9 > 1 > 5 (MEI, MSI, MTI, SEI, SSI, STI).
- Latency: a candidate appearing in cycle N gives InterruptPendingM=1 in N+1 (if ~StallW in N).
- While InterruptPendingM=1, cause and target are frozen. A new higher-priority source does not change them.
- If the candidate set becomes empty while pending (software clears an enable), InterruptPendingM drops next cycle.
- All RUN/MASK registers hold when StallW=1.
- States: RUN, WFI, MASK.
- RUN → MASK: TrapM & ~StallW. Outputs clear next cycle.
- MASK lasts exactly one un-stalled cycle with InterruptPendingM forced 0, so mstatus updates from the trap propagate. MASK → RUN.
- RUN → WFI: wfiM & ~StallW & ~InterruptPendingM & PE==0. Counter cleared.
  - If PE!=0 at WFI, WFI retires as a NOP with no WfiStallM.
- WFI: WfiStallM=1 (combinational from state). State and counter advance regardless of StallW, because StallW is caused by WfiStallM.
  - Wake condition: PE!=0, regardless of global enables or delegation. Wake → RUN, then normal scheduling.
  - Timeout applies when STATUS_TW & Priv!=M & (S_SUPPORTED|U_SUPPORTED). The counter increments each WFI cycle. Reaching WFI_TIMEOUT-1 → WfiTimeoutM=1 for exactly one cycle, state → RUN.
  - With TW=0 or Priv==M there is no timeout; the counter saturates at WFI_TIMEOUT-1.
  - Wake and timeout in the same cycle: wake wins, no timeout pulse.
- TrapM while in WFI (e.g. external debug/NMI path): → MASK, WfiStallM drops next cycle.
- Counter width: 8 bits.

Test Plan:
- Priv=M, MIE=1, MIP=MIE=0x888, MIDELEG=0 → next cycle InterruptPendingM=1, cause=11. TrapM pulse → one cycle pending=0 (MASK), then re-raise only if still enabled.
- Priv=S, SIE=1, MIDELEG=0x222, MIP=MIE=0x0A0 → cause=7, InterruptToSM=0 (M-target beats S-target). Then set MIE=0x020 → cause=5, InterruptToSM=1.
- Pending cause=7 asserted, then MIP bit 11 rises → cause stays 7 until TrapM. Clear MIE → pending drops the following cycle.
- Priv=U, TW=1, PE=0, wfiM → WfiStallM=1 for 15 cycles, WfiTimeoutM pulse on cycle 16 with WFI_TIMEOUT=16. Repeat with Priv=M → stalls indefinitely, no pulse.
- In WFI with MIE=0 (global), raise MIP=MIE=0x080 → wake next cycle, WfiStallM=0, InterruptPendingM stays 0. Wake on same cycle as timeout → no pulse.
- Reset asserted in WFI mid-count, and with StallW=1 holding pending → all outputs 0, state RUN, counter 0 next cycle.

Source files
------------

// File: rtl/csr_irq_scheduler.sv
// Interrupt selection/prioritisation against mstatus enables and privilege,
// plus the WFI sleep sequencer with the mstatus.TW illegal-instruction timeout.
module csr_irq_scheduler #(
  parameter int unsigned S_SUPPORTED = 1,
  parameter int unsigned U_SUPPORTED = 1,
  parameter int unsigned WFI_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallW,
  input  logic [11:0] MIP_REGW,
  input  logic [11:0] MIE_REGW,
  input  logic [11:0] MIDELEG_REGW,
  input  logic        STATUS_MIE,
  input  logic        STATUS_SIE,
  input  logic        STATUS_TW,
  input  logic [1:0]  PrivilegeModeW,
  input  logic        wfiM,
  input  logic        TrapM,
  output logic        InterruptPendingM,
  output logic [3:0]  InterruptCauseM,
  output logic        InterruptToSM,
  output logic        WfiStallM,
  output logic        WfiTimeoutM
);

  typedef enum logic [1:0] {ST_RUN, ST_WFI, ST_MASK} state_e;

  localparam logic [11:0] IRQ_MASK = 12'hAAA;
  localparam logic [8:0]  CNT_LAST = 9'(WFI_TIMEOUT - 1);
  localparam logic [1:0]  PRIV_M   = 2'b11;
  localparam logic [1:0]  PRIV_S   = 2'b01;
  localparam logic [1:0]  PRIV_U   = 2'b00;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [3:0]  cause_q, cause_d;
  logic        tos_q, tos_d;
  logic        tmo_q, tmo_d;

  logic [11:0] pe, deleg, m_set, s_set;
  logic        m_en, s_en, any_pe, tmo_en;
  logic        cand_vld, cand_tos, wfi_enter, wfi_expire;
  logic [3:0]  cand_cause;
  logic [8:0]  cnt_inc;

  // Fixed order MEI > MSI > MTI > SEI > SSI > STI.
  function automatic logic [3:0] prio_cause(input logic [11:0] set);
    if (set[11])     return 4'd11;
    else if (set[3]) return 4'd3;
    else if (set[7]) return 4'd7;
    else if (set[9]) return 4'd9;
    else if (set[1]) return 4'd1;
    else             return 4'd5;
  endfunction

  assign deleg      = (S_SUPPORTED != 0) ? MIDELEG_REGW : 12'h000;
  assign pe         = MIP_REGW & MIE_REGW & IRQ_MASK;
  assign any_pe     = |pe;
  assign m_en       = (PrivilegeModeW != PRIV_M) | STATUS_MIE;
  assign s_en       = (S_SUPPORTED != 0) &
                      ((PrivilegeModeW == PRIV_U) | ((PrivilegeModeW == PRIV_S) & STATUS_SIE));
  assign m_set      = m_en ? (pe & ~deleg) : 12'h000;
  assign s_set      = s_en ? (pe & deleg) : 12'h000;
  assign cand_vld   = (|m_set) | (|s_set);
  assign cand_tos   = ~(|m_set);
  assign cand_cause = prio_cause((|m_set) ? m_set : s_set);

  assign tmo_en     = STATUS_TW & (PrivilegeModeW != PRIV_M) &
                      ((S_SUPPORTED != 0) | (U_SUPPORTED != 0));
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign wfi_enter  = wfiM & ~pend_q & ~any_pe;
  assign wfi_expire = tmo_en & (cnt_inc >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      cause_q <= 4'd0;
      tos_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      tos_q   <= tos_d;
      tmo_q   <= tmo_d;
    end
  end

  // WFI ignores StallW: the stall it sees is the one WfiStallM itself causes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (!StallW) begin
          if (TrapM)          state_d = ST_MASK;
          else if (wfi_enter) state_d = ST_WFI;
        end
      end
      ST_WFI: begin
        if (TrapM)           state_d = ST_MASK;
        else if (any_pe)     state_d = ST_RUN;
        else if (wfi_expire) state_d = ST_RUN;
      end
      ST_MASK: begin
        if (!StallW) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    cause_d = cause_q;
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!StallW) begin
          if (TrapM || (!wfi_enter && !cand_vld)) begin
            pend_d  = 1'b0;
            cause_d = 4'd0;
            tos_d   = 1'b0;
          end else if (wfi_enter) begin
            cnt_d = 8'd0;
          end else if (!pend_q) begin
            pend_d  = 1'b1;
            cause_d = cand_cause;
            tos_d   = cand_tos;
          end
        end
      end
      ST_WFI: begin
        if (!TrapM && !any_pe) begin
          if (wfi_expire)               tmo_d = 1'b1;
          else if (cnt_inc <= CNT_LAST) cnt_d = cnt_inc[7:0];
        end
      end
      default: begin
        pend_d  = 1'b0;
        cause_d = 4'd0;
        tos_d   = 1'b0;
      end
    endcase
  end

  assign InterruptPendingM = pend_q;
  assign InterruptCauseM   = cause_q;
  assign InterruptToSM     = tos_q;
  assign WfiStallM         = (state_q == ST_WFI);
  assign WfiTimeoutM       = tmo_q;

endmodule
